// File: rtl/clock_divider_pkg.sv
// Shared types and constants for the clock divider sequencer.
package clock_divider_pkg;

  // Sequencer states: gate, wait for a quiet output, load, settle, re-enable.
  typedef enum logic [2:0] {
    CDS_IDLE   = 3'd0,
    CDS_DRAIN  = 3'd1,
    CDS_LOAD   = 3'd2,
    CDS_SETTLE = 3'd3,
    CDS_ENABLE = 3'd4,
    CDS_DONE   = 3'd5
  } cds_state_t;

  // Consecutive low samples of gclk needed before the ratio may change.
  localparam int DRAIN_LOW_RUN = 2;

  // Ratio field width able to hold max_ratio.
  function automatic int calc_div_w(input int max_ratio);
    return $clog2(max_ratio + 1);
  endfunction

  // Cycles allowed for the first sampled gclk rise after re-enable
  // (covers one full slowest period plus the sampler latency).
  function automatic int enable_timeout(input int max_ratio);
    return 2 * max_ratio + 2;
  endfunction

endpackage

// File: rtl/clock_divider_seq_gclk_edge_detect.sv
// Samples the divider output as data through two flops and flags rising edges.
module gclk_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic gclk,
  output logic gclk_s,
  output logic gclk_rise
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  // Next values of the sampler pipeline and the previous-sample register.
  always_comb begin
    meta_d = gclk;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // Sampler flops, cleared by reset so a stale high cannot fake an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign gclk_s    = sync_q;
  assign gclk_rise = sync_q & ~prev_q;

endmodule

// File: rtl/clock_divider_seq.sv
// Owns div/dis of one clock_divider and applies ratio/disable requests
// glitch-safely: gate, wait for gclk low, load ratio, settle, re-enable.
module clock_divider_seq
  import clock_divider_pkg::*;
#(
  parameter int MIN_RATIO     = 1,
  parameter int MAX_RATIO     = 64,
  parameter int RESET_DIV     = 1,
  parameter int SETTLE_CYCLES = 4,
  parameter int DIV_W         = calc_div_w(MAX_RATIO)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [DIV_W-1:0] req_div,
  input  logic             req_dis,
  output logic [DIV_W-1:0] div_o,
  output logic             dis_o,
  input  logic             gclk,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int EN_TIMEOUT    = enable_timeout(MAX_RATIO);
  localparam int DRAIN_TIMEOUT = 2 * MAX_RATIO;
  localparam int CNT_MAX       = (EN_TIMEOUT > SETTLE_CYCLES) ? EN_TIMEOUT : SETTLE_CYCLES;
  localparam int CNT_W         = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] DRAIN_LAST   = CNT_W'(DRAIN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ENABLE_LAST  = CNT_W'(EN_TIMEOUT - 1);
  localparam logic [1:0]       LOW_RUN_DONE = 2'(DRAIN_LOW_RUN);
  localparam logic [DIV_W-1:0] MIN_DIV      = DIV_W'(MIN_RATIO);
  localparam logic [DIV_W-1:0] MAX_DIV      = DIV_W'(MAX_RATIO);
  localparam logic [DIV_W-1:0] RST_DIV      = DIV_W'(RESET_DIV);

  cds_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       low_run_q, low_run_d;
  logic [DIV_W-1:0] cap_div_q, cap_div_d;
  logic             cap_dis_q, cap_dis_d;
  logic [DIV_W-1:0] div_o_q, div_o_d;
  logic             dis_o_q, dis_o_d;
  logic             req_ready_q, req_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic gclk_s;
  logic gclk_rise;

  gclk_edge_detect u_edge (
    .clk       (clk),
    .rst       (rst),
    .gclk      (gclk),
    .gclk_s    (gclk_s),
    .gclk_rise (gclk_rise)
  );

  // Next-state, divider controls and status outputs; outputs are registered
  // from the next state so they line up with the state they describe.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    low_run_d = low_run_q;
    cap_div_d = cap_div_q;
    cap_dis_d = cap_dis_q;
    div_o_d   = div_o_q;
    dis_o_d   = dis_o_q;
    err_d     = 1'b0;

    unique case (state_q)
      CDS_IDLE: begin
        cnt_d     = '0;
        low_run_d = '0;
        if (req_valid && req_ready_q) begin
          cap_div_d = req_div;
          cap_dis_d = req_dis;
          if ((req_div < MIN_DIV) || (req_div > MAX_DIV)) begin
            state_d = CDS_DONE;
            err_d   = 1'b1;
          end else if ((req_div == div_o_q) && (req_dis == dis_o_q)) begin
            state_d = CDS_DONE;
          end else begin
            state_d = CDS_DRAIN;
            dis_o_d = 1'b1;
          end
        end
      end

      CDS_DRAIN: begin
        // The first DRAIN cycle is the one in which the gate takes effect,
        // so its sample says nothing about the gated output; skip it.
        if (cnt_q != '0) begin
          low_run_d = gclk_s ? 2'd0 : (low_run_q + 2'd1);
        end
        // A stuck-high gclk must not hang the sequence; load anyway.
        if ((low_run_d == LOW_RUN_DONE) || (cnt_q == DRAIN_LAST)) begin
          state_d = CDS_LOAD;
          cnt_d   = '0;
        end
      end

      CDS_LOAD: begin
        div_o_d = cap_div_q;
        state_d = CDS_SETTLE;
        cnt_d   = '0;
      end

      CDS_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d = '0;
          if (cap_dis_q) begin
            state_d = CDS_DONE;
          end else begin
            state_d = CDS_ENABLE;
            dis_o_d = 1'b0;
          end
        end
      end

      CDS_ENABLE: begin
        // On timeout the divider stays enabled; only the error is reported.
        if (gclk_rise) begin
          state_d = CDS_DONE;
          cnt_d   = '0;
        end else if (cnt_q == ENABLE_LAST) begin
          state_d = CDS_DONE;
          cnt_d   = '0;
          err_d   = 1'b1;
        end
      end

      CDS_DONE: begin
        state_d = CDS_IDLE;
        cnt_d   = '0;
      end

      default: begin
        state_d = CDS_IDLE;
        cnt_d   = '0;
      end
    endcase

    req_ready_d = (state_d == CDS_IDLE);
    busy_d      = (state_d != CDS_IDLE);
    done_d      = (state_d == CDS_DONE);
  end

  // State and output registers; reset aborts any sequence without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CDS_IDLE;
      cnt_q       <= '0;
      low_run_q   <= '0;
      cap_div_q   <= RST_DIV;
      cap_dis_q   <= 1'b1;
      div_o_q     <= RST_DIV;
      dis_o_q     <= 1'b1;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      low_run_q   <= low_run_d;
      cap_div_q   <= cap_div_d;
      cap_dis_q   <= cap_dis_d;
      div_o_q     <= div_o_d;
      dis_o_q     <= dis_o_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign req_ready = req_ready_q;
  assign div_o     = div_o_q;
  assign dis_o     = dis_o_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_clock_divider_seq.sv
// Bench for clock_divider_seq with a behavioural 50%-duty divider attached.
module tb_clock_divider_seq;

  localparam int MAXR   = 64;
  localparam int SETTLE = 4;
  localparam int DW     = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [DW-1:0] req_div = '0;
  logic          req_dis = 1'b0;
  logic [DW-1:0] div_o;
  logic          dis_o;
  logic          gclk;
  logic          busy, done, err;

  logic gclk_div = 1'b0;
  logic stuck = 1'b0;
  int   hc = 0;

  int checks = 0;
  int errors = 0;

  // Reference state: what div_o/dis_o should be after the last request.
  int model_div = 1;
  bit model_dis = 1'b1;

  clock_divider_seq #(
    .MIN_RATIO     (1),
    .MAX_RATIO     (MAXR),
    .RESET_DIV     (1),
    .SETTLE_CYCLES (SETTLE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_div   (req_div),
    .req_dis   (req_dis),
    .div_o     (div_o),
    .dis_o     (dis_o),
    .gclk      (gclk),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Divider stand-in: toggles every div half-periods of clk, held low when gated.
  always @(posedge clk or negedge clk) begin
    if (dis_o) begin
      hc       <= 0;
      gclk_div <= 1'b0;
    end else if (hc + 1 >= int'(div_o)) begin
      hc       <= 0;
      gclk_div <= ~gclk_div;
    end else begin
      hc <= hc + 1;
    end
  end

  assign gclk = stuck ? 1'b0 : gclk_div;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // div_o may only move while the divider is (and already was) gated.
  logic [DW-1:0] prev_div;
  logic          prev_dis;
  bit            mon_en = 1'b0;
  always @(negedge clk) begin
    if (mon_en && !rst && (div_o !== prev_div)) begin
      chk("dis_at_div_change", dis_o, 1);
      chk("dis_before_div_change", prev_dis, 1);
    end
    prev_div = div_o;
    prev_dis = dis_o;
  end

  // Issue one request (called at a negedge), return latency in cycles to done.
  task automatic do_req(input int d, input bit ds, output int lat, output logic e);
    int n;
    req_div   = DW'(d);
    req_dis   = ds;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 400);
    e = err;
    chk("done_seen", done, 1);
    @(negedge clk);
    chk("done_single", done, 0);
  endtask

  task automatic req_and_check(input int d, input bit ds, output int lat);
    logic e;
    bit   exp_err, noop;
    exp_err = (d < 1) || (d > MAXR);
    noop    = !exp_err && (d == model_div) && (ds == model_dis);
    do_req(d, ds, lat, e);
    chk("err", e, exp_err);
    if (exp_err || noop) begin
      chk("lat_short", lat, 1);
    end else begin
      chk("lat_min", lat >= SETTLE + 5, 1);
      model_div = d;
      model_dis = ds;
    end
    chk("div_o", div_o, model_div);
    chk("dis_o", dis_o, model_dis);
    $display("REQ div=%0d dis=%0d lat=%0d err=%0d div_o=%0d dis_o=%0d", d, ds, lat, e, div_o, dis_o);
  endtask

  // Measure one full gclk period and its high time (in time units).
  task automatic measure(input int d);
    time t_r1, t_f, t_r2;
    int  stage, n;
    logic p;
    t_r1 = 0; t_f = 0; t_r2 = 0;
    stage = 0; n = 0;
    p = gclk;
    while (stage < 3 && n < 800) begin
      @(clk);
      #1;
      n++;
      if (!p && gclk) begin
        if (stage == 0) begin t_r1 = $time; stage = 1; end
        else if (stage == 2) begin t_r2 = $time; stage = 3; end
      end else if (p && !gclk && stage == 1) begin
        t_f = $time;
        stage = 2;
      end
      p = gclk;
    end
    chk("measure_edges", stage, 3);
    chk("gclk_period", int'(t_r2 - t_r1), 10 * d);
    chk("gclk_high", int'(t_f - t_r1), 5 * d);
    $display("PERIOD div=%0d period=%0d high=%0d", d, int'(t_r2 - t_r1), int'(t_f - t_r1));
    @(negedge clk);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, n, d, en_cycles, done_cnt;
    bit ds, noop;

    // Reset held for 5 cycles.
    rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("rst_dis_o", dis_o, 1);
      chk("rst_div_o", div_o, 1);
      chk("rst_req_ready", req_ready, 1);
      chk("rst_done", done, 0);
    end
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    $display("RESET dis_o=%0d div_o=%0d req_ready=%0d", dis_o, div_o, req_ready);
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // Disable-only request with gclk already low: exact latency.
    req_and_check(3, 1'b1, lat);
    chk("lat_disable_only", lat, SETTLE + 5);

    // Enable at ratio 4.
    req_and_check(4, 1'b0, lat);
    measure(4);

    // Out-of-range ratios and a no-op.
    req_and_check(0, 1'b0, lat);
    req_and_check(65, 1'b0, lat);
    req_and_check(4, 1'b0, lat);

    // Random individual requests.
    for (int i = 0; i < 10; i++) begin
      d  = $urandom_range(1, MAXR);
      ds = ($urandom_range(0, 3) == 0);
      req_and_check(d, ds, lat);
      if (!ds) measure(d);
    end

    // Back-to-back requests with req_valid held high.
    req_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      d  = $urandom_range(1, MAXR);
      ds = ($urandom_range(0, 3) == 0);
      req_div = DW'(d);
      req_dis = ds;
      n = 0;
      while (!req_ready && n < 400) begin
        @(negedge clk);
        n++;
      end
      @(posedge clk);
      #1;
      chk("b2b_busy_after_accept", busy, 1);
      chk("b2b_ready_after_accept", req_ready, 0);
      noop = (d == model_div) && (ds == model_dis);
      model_div = d;
      model_dis = ds;
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (!done && lat < 400);
      chk("b2b_done", done, 1);
      chk("b2b_err", err, 0);
      chk("b2b_div_o", div_o, model_div);
      chk("b2b_dis_o", dis_o, model_dis);
      if (noop) chk("b2b_lat_noop", lat, 1);
      $display("B2B %0d div=%0d dis=%0d lat=%0d err=%0d", i, d, ds, lat, err);
    end
    req_valid = 1'b0;
    @(negedge clk);

    // Stuck gclk: enable at ratio 8 must time out after 130 enabled cycles.
    req_and_check(7, 1'b1, lat);
    stuck     = 1'b1;
    req_div   = DW'(8);
    req_dis   = 1'b0;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    en_cycles = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!dis_o && !done) en_cycles++;
    end while (!done && lat < 600);
    chk("stuck_done", done, 1);
    chk("stuck_err", err, 1);
    chk("stuck_enable_cycles", en_cycles, 2 * MAXR + 2);
    chk("stuck_dis_o", dis_o, 0);
    $display("STUCK div=8 lat=%0d enable_cycles=%0d err=%0d dis_o=%0d", lat, en_cycles, err, dis_o);
    @(negedge clk);
    chk("stuck_dis_after", dis_o, 0);
    model_div = 8;
    model_dis = 1'b0;
    stuck = 1'b0;

    // Reset during SETTLE (first cycle with the new ratio loaded).
    req_div   = DW'(5);
    req_dis   = 1'b0;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (div_o !== DW'(5) && n < 400);
    chk("mid_settle_div", div_o, 5);
    chk("mid_settle_dis", dis_o, 1);
    chk("mid_settle_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_dis_o", dis_o, 1);
    chk("mid_rst_div_o", div_o, 1);
    chk("mid_rst_ready", req_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("mid_rst_no_done", done_cnt, 0);
    $display("MIDRST dis_o=%0d div_o=%0d done_pulses=%0d", dis_o, div_o, done_cnt);
    model_div = 1;
    model_dis = 1'b1;

    // Normal operation after the abort.
    req_and_check(2, 1'b0, lat);
    measure(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
